dead_time_inserter: RTL and testbench

- Three-phase gate-drive stage directly downstream of the modulator.
- Takes the modulator's per-phase 2-bit switch commands ({high-side, low-side}) and drives the gate signals.
- Guarantees a programmable dead time with both switches off whenever a phase commutates, so the high-side and low-side switches never conduct together.
- Rejects illegal commands and flags them.

---
 rtl/dead_time_inserter.sv | 130 +++++++++++++
 tb/tb_dead_time_inserter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dead_time_inserter.sv
// Three-phase dead-time inserter. Each phase has its own FSM that turns the
// modulator's {hi,lo} switch command into gate drives. Whenever a phase
// changes between HI and LO, both gates stay off for DT_CYCLES clocks, so the
// two switches of a leg can never conduct at the same time.
// Gate outputs come only from registered state. Nothing from in*/en reaches
// g* combinationally, and the value 2'b11 can never be produced.
module dead_time_inserter #(
  parameter int DT_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       en,
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  input  logic [1:0] in3,
  output logic [1:0] g1,
  output logic [1:0] g2,
  output logic [1:0] g3,
  output logic [2:0] illegal
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Count value on the last cycle of the dead interval. The DEAD state is
  // entered with cnt=0, so DT_CYCLES cycles of 00 are produced in total.
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DT_CYCLES - 1);

  logic [2:0][1:0] cmd_w;
  logic [2:0][1:0] gate_w;

  assign cmd_w[0] = in1;
  assign cmd_w[1] = in2;
  assign cmd_w[2] = in3;

  assign g1 = gate_w[0];
  assign g2 = gate_w[1];
  assign g3 = gate_w[2];

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gate_q, gate_d;
    logic             ill_q, ill_d;
    logic             req_hi, req_lo;

    // Effective request: with en low, or for 00/11, the request is off.
    always_comb begin
      req_hi = en && (cmd_w[gi] == 2'b10);
      req_lo = en && (cmd_w[gi] == 2'b01);
    end

    // Next-state, dead-time counter, gate decode and sticky illegal flag.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ill_d   = ill_q | (cmd_w[gi] == 2'b11);
      unique case (state_q)
        ST_OFF: begin
          // Gates are already off, so either side may switch on at once.
          if (req_hi) begin
            state_d = ST_HI;
          end else if (req_lo) begin
            state_d = ST_LO;
          end
        end
        ST_HI: begin
          if (!req_hi) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
          end
        end
        ST_LO: begin
          if (!req_lo) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
          end
        end
        ST_DEAD: begin
          // The timer keeps running whatever the request does. The
          // request is only looked at on the final edge.
          if (cnt_q != DT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else if (req_hi) begin
            state_d = ST_HI;
          end else if (req_lo) begin
            state_d = ST_LO;
          end else begin
            state_d = ST_OFF;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase

      // The gate register is loaded from the state it is entering, so the
      // output always matches the registered state.
      unique case (state_d)
        ST_HI:   gate_d = 2'b10;
        ST_LO:   gate_d = 2'b01;
        default: gate_d = 2'b00;
      endcase
    end

    // Phase state registers. Reset clears them without waiting for clk.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        gate_q  <= 2'b00;
        ill_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        gate_q  <= gate_d;
        ill_q   <= ill_d;
      end
    end

    assign gate_w[gi]  = gate_q;
    assign illegal[gi] = ill_q;
  end

endmodule

// File: tb/tb_dead_time_inserter.sv
// Directed tests and a randomized property check for dead_time_inserter,
// run with DT_CYCLES=4.
module tb_dead_time_inserter;
  localparam int DT = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] in1, in2, in3;
  logic [1:0] g1, g2, g3;
  logic [2:0] illegal;

  int errors = 0;
  int checks = 0;

  dead_time_inserter #(.DT_CYCLES(DT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in1(in1), .in2(in2), .in3(in3),
    .g1(g1), .g2(g2), .g3(g3), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle. Inputs driven after this call are
  // sampled at the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; in1 = 2'b10; in2 = 2'b01; in3 = 2'b11;
    #2;
    checks++;
    if ({g1, g2, g3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_gates: got %b %b %b, want 00 00 00", g1, g2, g3);
    end
    tick();
    tick();
    checks++;
    if ({g1, g2, g3, illegal} !== 9'b0) begin
      errors++;
      $display("FAIL reset_held: got g=%b %b %b illegal=%b, want all 0", g1, g2, g3, illegal);
    end
    in1 = 2'b00; in2 = 2'b00; in3 = 2'b00;
    rst = 1'b1;
    tick();
    checks++;
    if ({g1, g2, g3, illegal} !== 9'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got g=%b %b %b illegal=%b, want all 0", g1, g2, g3, illegal);
    end
    $display("test_reset done");
  endtask

  task automatic test_commutation();
    logic [1:0] exp [0:5];
    exp[0] = 2'b00; exp[1] = 2'b00; exp[2] = 2'b00; exp[3] = 2'b00; exp[4] = 2'b01; exp[5] = 2'b01;
    in1 = 2'b10;
    tick();
    checks++;
    if (g1 !== 2'b10) begin
      errors++;
      $display("FAIL off_to_hi: g1=%b want 10", g1);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (g1 !== 2'b10) begin
      errors++;
      $display("FAIL hi_hold: g1=%b want 10", g1);
    end
    in1 = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (g1 !== exp[i]) begin
        errors++;
        $display("FAIL hi_to_lo_step%0d: g1=%b want %b", i, g1, exp[i]);
      end
    end
    $display("test_commutation done");
  endtask

  task automatic test_no_restart();
    logic [1:0] exp [0:4];
    exp[0] = 2'b00; exp[1] = 2'b00; exp[2] = 2'b00; exp[3] = 2'b00; exp[4] = 2'b10;
    in2 = 2'b01;
    tick();
    checks++;
    if (g2 !== 2'b01) begin
      errors++;
      $display("FAIL off_to_lo: g2=%b want 01", g2);
    end
    in2 = 2'b00;
    tick();
    checks++;
    if (g2 !== exp[0]) begin
      errors++;
      $display("FAIL norestart_step0: g2=%b want %b", g2, exp[0]);
    end
    in2 = 2'b10;
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (g2 !== exp[i]) begin
        errors++;
        $display("FAIL norestart_step%0d: g2=%b want %b", i, g2, exp[i]);
      end
    end
    $display("test_no_restart done");
  endtask

  task automatic test_en_drop();
    // g1=01 and g2=10 at this point. Change them to 10 and 01, and let the
    // dead time run out.
    in1 = 2'b10; in2 = 2'b01; in3 = 2'b10;
    for (int i = 0; i < DT + 2; i++) tick();
    checks++;
    if ({g1, g2, g3} !== 6'b10_01_10) begin
      errors++;
      $display("FAIL all_on: got %b %b %b want 10 01 10", g1, g2, g3);
    end
    en = 1'b0;
    for (int i = 0; i < DT + 3; i++) begin
      tick();
      checks++;
      if ({g1, g2, g3} !== 6'b0) begin
        errors++;
        $display("FAIL en_low_step%0d: got %b %b %b want 00 00 00", i, g1, g2, g3);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({g1, g2, g3} !== 6'b10_01_10) begin
      errors++;
      $display("FAIL en_restore: got %b %b %b want 10 01 10", g1, g2, g3);
    end
    $display("test_en_drop done");
  endtask

  task automatic test_illegal();
    checks++;
    if (illegal !== 3'b000) begin
      errors++;
      $display("FAIL illegal_clear: illegal=%b want 000", illegal);
    end
    in3 = 2'b11;
    tick();
    checks++;
    if (g3 !== 2'b00 || illegal !== 3'b100) begin
      errors++;
      $display("FAIL illegal_hit: g3=%b illegal=%b want 00 100", g3, illegal);
    end
    in3 = 2'b00;
    for (int i = 1; i < DT + 3; i++) begin
      tick();
      checks++;
      if (g3 !== 2'b00) begin
        errors++;
        $display("FAIL illegal_dead_step%0d: g3=%b want 00", i, g3);
      end
    end
    in3 = 2'b10;
    tick();
    checks++;
    if (g3 !== 2'b10 || illegal !== 3'b100) begin
      errors++;
      $display("FAIL illegal_sticky: g3=%b illegal=%b want 10 100", g3, illegal);
    end
    $display("test_illegal done");
  endtask

  task automatic test_async_reset();
    // g1 is 10 here. Pull the reset low between edges.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({g1, g2, g3, illegal} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset: g=%b %b %b illegal=%b want all 0", g1, g2, g3, illegal);
    end
    tick();
    rst = 1'b1; in1 = 2'b10; in2 = 2'b00; in3 = 2'b00;
    tick();
    checks++;
    if (g1 !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_hi: g1=%b want 10", g1);
    end
    // Reset during a dead interval. The first edge after release must act
    // as it would from OFF.
    in1 = 2'b01;
    tick();
    tick();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (g1 !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_dead: g1=%b want 00", g1);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (g1 !== 2'b01) begin
      errors++;
      $display("FAIL reset_dead_abort: g1=%b want 01", g1);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [1:0] gs     [3];
    logic [1:0] last_nz[3];
    int         zc     [3];
    logic [5:0] early;
    for (int k = 0; k < 3; k++) begin
      last_nz[k] = 2'b00;
      zc[k]      = 0;
    end
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      early = {g1, g2, g3};
      // Change the inputs in the middle of the cycle. With no combinational
      // path to g*, the outputs must not move before the next edge.
      en  = ($urandom_range(0, 15) != 0);
      in1 = 2'($urandom_range(0, 3));
      in2 = 2'($urandom_range(0, 3));
      in3 = 2'($urandom_range(0, 3));
      #7;
      checks++;
      if ({g1, g2, g3} !== early) begin
        errors++;
        $display("FAIL rnd_glitch cyc%0d: g=%b want stable %b", c, {g1, g2, g3}, early);
      end
      gs[0] = g1; gs[1] = g2; gs[2] = g3;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gs[k] === 2'b11) begin
          errors++;
          $display("FAIL rnd_shoot_through cyc%0d phase%0d: g=11 want not 11", c, k + 1);
        end
        if (gs[k] === 2'b00) begin
          zc[k]++;
        end else begin
          checks++;
          if (last_nz[k] !== 2'b00 && gs[k] !== last_nz[k] && zc[k] < DT) begin
            errors++;
            $display("FAIL rnd_deadtime cyc%0d phase%0d: gap=%0d want >= %0d", c, k + 1, zc[k], DT);
          end
          last_nz[k] = gs[k];
          zc[k]      = 0;
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_commutation();
    test_no_restart();
    test_en_drop();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
